mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs, performs the data-memory load or store, and registers the results into the MEM/WB boundary for writeback.
- Models a word-addressed data RAM with a configurable number of read wait states. Raises a combinational stall so the EX/MEM register and everything upstream freeze while a load is pending.
- Flags misaligned accesses and squashes them.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit data memory words (power of 2, 4..65536); ADDR_BITS = clog2(DEPTH_WORDS).
- WAIT_STATES, 2, extra stall cycles per load (0..15); 0 gives a single-cycle load.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flushInput  in  1  synchronous squash of the current instruction
- memToRegInput  in  1  from EX/MEM: writeback selects load data
- regWriteInput  in  1  from EX/MEM: instruction writes the register file
- memWriteInput  in  1  from EX/MEM: store
- memReadInput  in  1  from EX/MEM: load
- aluResultInput  in  32  from EX/MEM: effective address / ALU value
- memWriteDataInput  in  32  from EX/MEM: store data
- regWriteAddressInput  in  5  from EX/MEM: destination register
- stallOutput  out  1  combinational; high = upstream must hold all state
- memToRegOutput  out  1  to MEM/WB (registered)
- regWriteOutput  out  1  to MEM/WB (registered)
- readDataOutput  out  32  load data (registered)
- aluResultOutput  out  32  passthrough of aluResultInput (registered)
- regWriteAddressOutput  out  5  passthrough (registered)
- misalignedOutput  out  1  one-cycle pulse, registered, for a squashed misaligned access

Behaviour:
- Reset (clk is the clock; reset is synchronous, active-high): all registered outputs go to 0, FSM goes to IDLE, counter goes to 0, stallOutput is 0 the following cycle. RAM contents are not reset. Reset overrides flush and any pending load, including mid-WAIT.
- Addressing: word index = aluResultInput[ADDR_BITS+1:2]. Upper bits are ignored, so addresses alias modulo 4*DEPTH_WORDS.
- aligned = (aluResultInput[1:0] == 0).
- rd = memReadInput & ~memWriteInput & aligned.
- wr = memWriteInput & aligned.
- If memReadInput and memWriteInput are both high, the access is treated as a store only and readDataOutput is 0.
- Misaligned (memRead|memWrite with addr[1:0] != 0):
  - no RAM access and no stall;
  - outputs are a bubble (regWrite=0, memToReg=0);
  - misalignedOutput=1 for one cycle; aluResultOutput and regWriteAddressOutput still pass through.
- Bubble definition: regWriteOutput=0, memToRegOutput=0, readDataOutput=0. aluResultOutput and regWriteAddressOutput are still captured.
- FSM states are IDLE and WAIT, with a 4-bit counter cnt.
- IDLE behaviour:
  - stallOutput = rd & (WAIT_STATES > 0) & ~flushInput.
  - If stallOutput: next state WAIT, cnt <= WAIT_STATES-1, outputs <= bubble.
  - Otherwise the outputs capture the instruction:
    - store: RAM[idx] <= memWriteDataInput at this edge, readDataOutput <= 0;
    - load (WAIT_STATES=0): readDataOutput <= RAM[idx];
    - neither: readDataOutput <= 0;
    - control bits pass through.
- WAIT behaviour:
  - stallOutput = (cnt != 0).
  - If cnt != 0: cnt decrements and outputs <= bubble.
  - If cnt == 0: readDataOutput <= RAM[idx] and control bits pass through; next state IDLE.
- Load timing: presented in cycle 0, stallOutput high for exactly WAIT_STATES cycles (0..WAIT_STATES-1), result visible on outputs in cycle WAIT_STATES+1.
- Upstream inputs must stay stable while stallOutput=1.
- Stores never stall and never occur in WAIT.
- Store-to-load ordering: a load immediately following a store to the same word returns the stored data.
- Flush:
  - outputs <= bubble and misalignedOutput <= 0;
  - the store is suppressed and the FSM goes to IDLE, so a pending load is aborted with no result;
  - stallOutput is forced 0 in the flush cycle.

Test Plan:
- Reset, then idle with all inputs 0 -> all outputs 0, stallOutput 0 throughout.
- Store 0xDEADBEEF to address 0x10, then load from 0x10 with regWrite=1, memToReg=1, rd=5, WAIT_STATES=2 -> stallOutput high for exactly 2 cycles, two bubbles, then readDataOutput=0xDEADBEEF, regWriteAddressOutput=5, regWriteOutput=1.
- WAIT_STATES=0: back-to-back store 0x1 to 0x0, then load from 0x0 -> no stall, readDataOutput=0x1 one cycle after the load.
- Load from address 0x6 -> no stall, misalignedOutput pulses 1 for one cycle, regWriteOutput=0, RAM unchanged.
- Aliasing with DEPTH_WORDS=256: store 0xA5 to 0x400, load from 0x0 -> returns 0xA5.
- Assert flushInput in cycle 1 of a WAIT_STATES=3 load -> stall drops immediately, no load result, FSM back in IDLE. Repeat with reset instead of flush mid-WAIT -> outputs 0 the next cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data RAM access with configurable load
// wait states, misaligned-access squashing, and the MEM/WB output register.
module mem_access_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flushInput,
  input  logic        memToRegInput,
  input  logic        regWriteInput,
  input  logic        memWriteInput,
  input  logic        memReadInput,
  input  logic [31:0] aluResultInput,
  input  logic [31:0] memWriteDataInput,
  input  logic [4:0]  regWriteAddressInput,
  output logic        stallOutput,
  output logic        memToRegOutput,
  output logic        regWriteOutput,
  output logic [31:0] readDataOutput,
  output logic [31:0] aluResultOutput,
  output logic [4:0]  regWriteAddressOutput,
  output logic        misalignedOutput
);

  localparam int       ADDR_BITS = $clog2(DEPTH_WORDS);
  localparam bit       HAS_WAIT  = (WAIT_STATES != 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic [ADDR_BITS-1:0] idx;
  logic aligned, misaligned, rd, wr;
  logic ram_we, stall;
  logic n_mem_to_reg, n_reg_write, n_misaligned;
  logic [31:0] n_read_data;

  // Upper address bits are dropped, so addresses alias modulo the RAM size.
  assign idx        = aluResultInput[ADDR_BITS+1:2];
  assign aligned    = (aluResultInput[1:0] == 2'b00);
  assign misaligned = (memReadInput | memWriteInput) & ~aligned;
  assign rd         = memReadInput & ~memWriteInput & aligned;
  assign wr         = memWriteInput & aligned;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    stall        = 1'b0;
    ram_we       = 1'b0;
    n_mem_to_reg = 1'b0;
    n_reg_write  = 1'b0;
    n_read_data  = '0;
    n_misaligned = 1'b0;
    if (flushInput) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rd && HAS_WAIT) begin
            stall      = 1'b1;
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end else if (misaligned) begin
            n_misaligned = 1'b1;
          end else begin
            n_mem_to_reg = memToRegInput;
            n_reg_write  = regWriteInput;
            ram_we       = wr;
            if (rd) n_read_data = mem[idx];
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            stall    = 1'b1;
            cnt_next = cnt - 4'd1;
          end else begin
            state_next   = S_IDLE;
            n_mem_to_reg = memToRegInput;
            n_reg_write  = regWriteInput;
            if (rd) n_read_data = mem[idx];
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign stallOutput = stall;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= S_IDLE;
      cnt                   <= '0;
      memToRegOutput        <= 1'b0;
      regWriteOutput        <= 1'b0;
      readDataOutput        <= '0;
      aluResultOutput       <= '0;
      regWriteAddressOutput <= '0;
      misalignedOutput      <= 1'b0;
    end else begin
      state                 <= state_next;
      cnt                   <= cnt_next;
      memToRegOutput        <= n_mem_to_reg;
      regWriteOutput        <= n_reg_write;
      readDataOutput        <= n_read_data;
      aluResultOutput       <= aluResultInput;
      regWriteAddressOutput <= regWriteAddressInput;
      misalignedOutput      <= n_misaligned;
    end
  end

  // NOTE: the RAM array has no reset; only the write is blocked while reset is high.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) mem[idx] <= memWriteDataInput;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: three instances (2, 0 and 3 wait
// states) driven from a vector table with a scoreboard queue, plus reset corners.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        flush_i [3], m2r_i [3], rw_i [3], mw_i [3], mr_i [3];
  logic [31:0] alu_i [3], wd_i [3];
  logic [4:0]  wa_i [3];
  logic        stall_o [3], m2r_o [3], rw_o [3], mis_o [3];
  logic [31:0] rd_o [3], alu_o [3];
  logic [4:0]  wa_o [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_stage #(
      .DEPTH_WORDS(256),
      .WAIT_STATES(g == 0 ? 2 : (g == 1 ? 0 : 3))
    ) dut (
      .clk                  (clk),
      .reset                (reset),
      .flushInput           (flush_i[g]),
      .memToRegInput        (m2r_i[g]),
      .regWriteInput        (rw_i[g]),
      .memWriteInput        (mw_i[g]),
      .memReadInput         (mr_i[g]),
      .aluResultInput       (alu_i[g]),
      .memWriteDataInput    (wd_i[g]),
      .regWriteAddressInput (wa_i[g]),
      .stallOutput          (stall_o[g]),
      .memToRegOutput       (m2r_o[g]),
      .regWriteOutput       (rw_o[g]),
      .readDataOutput       (rd_o[g]),
      .aluResultOutput      (alu_o[g]),
      .regWriteAddressOutput(wa_o[g]),
      .misalignedOutput     (mis_o[g])
    );
  end

  typedef struct {
    int          d;
    logic        fl, m2r, rw, mw, mr;
    logic [31:0] alu, wd;
    logic [4:0]  wa;
    logic        e_stall, e_m2r, e_rw, e_mis;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    int          d;
    logic        m2r, rw, mis;
    logic [31:0] rd, alu;
    logic [4:0]  wa;
  } exp_t;

  vec_t vecs [$];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int d, input logic fl, input logic m2r, input logic rw,
                     input logic mw, input logic mr, input logic [31:0] alu,
                     input logic [31:0] wd, input logic [4:0] wa, input logic e_stall,
                     input logic e_m2r, input logic e_rw, input logic [31:0] e_rd,
                     input logic e_mis);
    vec_t v;
    v.d = d; v.fl = fl; v.m2r = m2r; v.rw = rw; v.mw = mw; v.mr = mr;
    v.alu = alu; v.wd = wd; v.wa = wa; v.e_stall = e_stall;
    v.e_m2r = e_m2r; v.e_rw = e_rw; v.e_rd = e_rd; v.e_mis = e_mis;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input int d);
    add(d, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic add_store(input int d, input logic fl, input logic [31:0] a, input logic [31:0] data);
    add(d, fl, 0, 0, 1, 0, a, data, 5'd0, 0, 0, 0, 32'h0, 0);
  endtask

  // A load stalls for ws cycles with bubbles, then returns data with control bits set.
  task automatic add_load(input int d, input int ws, input logic [31:0] a,
                          input logic [4:0] wa, input logic [31:0] data);
    for (int i = 0; i < ws; i++) add(d, 0, 1, 1, 0, 1, a, 32'h0, wa, 1, 0, 0, 32'h0, 0);
    add(d, 0, 1, 1, 0, 1, a, 32'h0, wa, 0, 1, 1, data, 0);
  endtask

  task automatic zero_inputs();
    for (int i = 0; i < 3; i++) begin
      flush_i[i] = 0; m2r_i[i] = 0; rw_i[i] = 0; mw_i[i] = 0; mr_i[i] = 0;
      alu_i[i] = '0; wd_i[i] = '0; wa_i[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    zero_inputs();
    reset = 1'b1;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset rw[%0d]", i), 32'(rw_o[i]), 32'h0);
      check($sformatf("reset rdata[%0d]", i), rd_o[i], 32'h0);
    end
    check("reset m2r", 32'(m2r_o[0]), 32'h0);
    check("reset alu", alu_o[0], 32'h0);
    check("reset wa", 32'(wa_o[0]), 32'h0);
    check("reset mis", 32'(mis_o[0]), 32'h0);
    reset = 1'b0;
    #1;
    check("post-reset stall", 32'(stall_o[0]), 32'h0);

    // 2 wait states
    add_idle(0);
    add_idle(0);
    add_store(0, 0, 32'h10, 32'hDEADBEEF);
    add_load(0, 2, 32'h10, 5'd5, 32'hDEADBEEF);
    add_store(0, 0, 32'h4, 32'h11111111);
    add(0, 0, 0, 0, 1, 0, 32'h6, 32'h22222222, 5'd0, 0, 0, 0, 32'h0, 1);
    add(0, 0, 1, 1, 0, 1, 32'h6, 32'h0, 5'd7, 0, 0, 0, 32'h0, 1);
    add_idle(0);
    add_load(0, 2, 32'h4, 5'd2, 32'h11111111);
    add_store(0, 0, 32'h400, 32'hA5);
    add_load(0, 2, 32'h0, 5'd4, 32'hA5);
    add(0, 0, 0, 1, 1, 1, 32'h20, 32'h77, 5'd6, 0, 0, 1, 32'h0, 0);
    add_load(0, 2, 32'h20, 5'd6, 32'h77);
    add(0, 0, 0, 1, 0, 0, 32'h1234, 32'h0, 5'd9, 0, 0, 1, 32'h0, 0);
    add(0, 1, 0, 1, 0, 0, 32'h1234, 32'h0, 5'd9, 0, 0, 0, 32'h0, 0);
    // 0 wait states
    add_store(1, 0, 32'h0, 32'h1);
    add_load(1, 0, 32'h0, 5'd1, 32'h1);
    add_idle(1);
    // 3 wait states: flush mid-WAIT, then a full load, then a flushed store
    add_store(2, 0, 32'h8, 32'h33);
    add(2, 0, 1, 1, 0, 1, 32'h8, 32'h0, 5'd3, 1, 0, 0, 32'h0, 0);
    add(2, 1, 1, 1, 0, 1, 32'h8, 32'h0, 5'd3, 0, 0, 0, 32'h0, 0);
    add_idle(2);
    add_load(2, 3, 32'h8, 5'd3, 32'h33);
    add_store(2, 1, 32'h8, 32'h44);
    add_load(2, 3, 32'h8, 5'd3, 32'h33);

    foreach (vecs[k]) begin
      vec_t v;
      exp_t e, got;
      v = vecs[k];
      zero_inputs();
      flush_i[v.d] = v.fl; m2r_i[v.d] = v.m2r; rw_i[v.d] = v.rw;
      mw_i[v.d] = v.mw; mr_i[v.d] = v.mr; alu_i[v.d] = v.alu;
      wd_i[v.d] = v.wd; wa_i[v.d] = v.wa;
      #1;
      check($sformatf("v%0d stall", k), 32'(stall_o[v.d]), 32'(v.e_stall));
      e.d = v.d; e.m2r = v.e_m2r; e.rw = v.e_rw; e.mis = v.e_mis;
      e.rd = v.e_rd; e.alu = v.alu; e.wa = v.wa;
      sb.push_back(e);
      step();
      got = sb.pop_front();
      check($sformatf("v%0d m2r", k), 32'(m2r_o[got.d]), 32'(got.m2r));
      check($sformatf("v%0d rw", k), 32'(rw_o[got.d]), 32'(got.rw));
      check($sformatf("v%0d rdata", k), rd_o[got.d], got.rd);
      check($sformatf("v%0d alu", k), alu_o[got.d], got.alu);
      check($sformatf("v%0d wa", k), 32'(wa_o[got.d]), 32'(got.wa));
      check($sformatf("v%0d mis", k), 32'(mis_o[got.d]), 32'(got.mis));
    end

    // Reset in the middle of a 3-wait-state load
    zero_inputs();
    mr_i[2] = 1; rw_i[2] = 1; m2r_i[2] = 1; alu_i[2] = 32'h8; wa_i[2] = 5'd3;
    #1;
    check("rst-mid stall before", 32'(stall_o[2]), 32'h1);
    step();
    reset = 1'b1;
    step();
    check("rst-mid rw", 32'(rw_o[2]), 32'h0);
    check("rst-mid m2r", 32'(m2r_o[2]), 32'h0);
    check("rst-mid rdata", rd_o[2], 32'h0);
    check("rst-mid alu", alu_o[2], 32'h0);
    check("rst-mid wa", 32'(wa_o[2]), 32'h0);
    reset = 1'b0;
    zero_inputs();
    #1;
    check("rst-mid stall after", 32'(stall_o[2]), 32'h0);
    step();
    check("rst-mid idle rw", 32'(rw_o[2]), 32'h0);
    check("rst-mid idle rdata", rd_o[2], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
